paralelo_serial_param: RTL

PARALELO_SERIAL_PARAM -- requirements
Module: paralelo_serial_param

---
 rtl/paralelo_serial_param.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/paralelo_serial_param.sv
// paralelo_serial_param
// Parallel-to-serial converter with a small input FIFO. Words are queued on a
// valid/ready handshake and sent as back-to-back fixed-length frames. When the
// FIFO is empty at a frame boundary, the COMMA word is sent instead.
//
// Handshake: a word transfers on a rising edge where valid_in && ready_out.
// ready_out comes only from registered state. A word offered while ready_out
// is low is dropped; the source must hold it until it sees ready_out high.
//
// Optional feature: define PS_PARITY_EN to append one even-parity bit to every
// frame (frame length WIDTH+1). When it is undefined the frame length is WIDTH
// and no parity logic is built.
//
// Parameters:
//   WIDTH     parallel word width (>=2)
//   DEPTH     FIFO entries (power of 2, >=2)
//   COMMA     idle word sent when the FIFO is empty at a frame boundary
//   MSB_FIRST 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// Ports:
//   clk_32f      sole clock, rising edge
//   reset        synchronous, active-high
//   valid_in     in_data holds a word this cycle
//   in_data      parallel word
//   ready_out    FIFO can take a word this cycle
//   out_serial   serial bit stream
//   frame_start  high during the first bit of every frame
//   data_active  high for every bit of a frame that carries FIFO data
module paralelo_serial_param #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] COMMA     = WIDTH'(8'hBC),
  parameter int               MSB_FIRST = 1
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] in_data,
  output logic             ready_out,
  output logic             out_serial,
  output logic             frame_start,
  output logic             data_active
);

`ifdef PS_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW   = $clog2(F);
  localparam int AW   = $clog2(DEPTH);
  localparam int OCCW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [F-1:0]     shreg;
  logic [F-1:0]     shifted;
  logic [F-1:0]     load_vec;
  logic [WIDTH-1:0] head_word;
  logic             active_q;
  logic             load;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OCCW-1:0]  occ;
  logic             empty, full, push, pop;

  assign empty = (occ == '0);
  assign full  = (occ == OCCW'(DEPTH));

  // ready_out is held low in reset and during the single IDLE cycle.
  assign ready_out = (state_q == SHIFT) && !full;
  assign push      = valid_in && ready_out;
  // Pop decides on the registered occupancy, so a word pushed on the same
  // edge as a load is never bypassed into the frame being loaded.
  assign pop       = load && !empty;

  // Next-state / load decision.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = SHIFT;
        load    = 1'b1;
      end
      SHIFT: begin
        load = (cnt == CW'(F - 1));
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame word to load and the shifted register contents.
  always_comb begin
    head_word = empty ? COMMA : mem[rd_ptr];
`ifdef PS_PARITY_EN
    // Parity bit always sits in the last transmitted position.
    if (MSB_FIRST != 0) load_vec = {head_word, ^head_word};
    else                load_vec = {^head_word, head_word};
`else
    load_vec = head_word;
`endif
    if (MSB_FIRST != 0) shifted = {shreg[F-2:0], 1'b0};
    else                shifted = {1'b0, shreg[F-1:1]};
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt      <= '0;
        shreg    <= load_vec;
        active_q <= !empty;
      end else begin
        cnt   <= cnt + CW'(1);
        shreg <= shifted;
      end
    end
  end

  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_32f) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCCW'(1);
        2'b01:   occ <= occ - OCCW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign out_serial  = (MSB_FIRST != 0) ? shreg[F-1] : shreg[0];
  assign frame_start = (state_q == SHIFT) && (cnt == '0);
  assign data_active = active_q;

endmodule
